alu_regfile_seq: RTL and testbench
==================================

# alu_regfile_seq

Operand-issue and writeback sequencer for the 8-bit ALU. It holds an 8-entry × 8-bit register file and accepts one instruction at a time over a valid/ready handshake. It drives the ALU's control and operand inputs from registered values, captures the ALU result, and writes it back. It sits directly upstream of the ALU and also consumes its result, closing the datapath loop.

## Interface
- ZERO_REG, default 1: when 1, r0 always reads 0 and writes to it are discarded; when 0, r0 is an ordinary register.
- ERR_W, default 8: width of the illegal-op counter.

- clk  in  1  sole clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept an instruction
- instr_ld  in  1  1 = load immediate (ALU bypassed); 0 = ALU op
- instr_op  in  3  ALU opcode: ADD 010, SUB 110, AND 000, OR 001, SLT 111
- instr_rd, instr_ra, instr_rb  in  3 each  destination / source A / source B register
- instr_imm  in  8  immediate for load
- alu_control  out  3  opcode to ALU
- alu_a, alu_b  out  8 each  operands to ALU
- alu_result  in  8  combinational ALU result
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  3  writeback destination
- wb_data  out  8  writeback value
- illegal  out  1  one-cycle pulse: rejected opcode
- err_count  out  ERR_W  saturating count of illegal opcodes
- dbg_addr  in  3  debug read address
- dbg_data  out  8  combinational register-file read at dbg_addr

## Operation
- FSM states: IDLE, EXEC, WB. instr_ready = (state == IDLE) && rst_n.
- IDLE: on instr_valid && instr_ready:
  - latch ld, op, rd and imm.
  - Read regfile[ra] and regfile[rb] into operand registers opa/opb (r0 reads 0 when ZERO_REG=1).
  - Go to EXEC.
- EXEC:
  - alu_control = op, alu_a = opa, alu_b = opb.
  - Capture into the result register: imm if ld, else alu_result.
  - Go to WB.
- WB:
  - wb_valid = 1, wb_rd = rd, wb_data = result register.
  - Write regfile[rd] (suppressed for rd=0 when ZERO_REG=1; wb_valid still asserts).
  - Go to IDLE.
- Illegal opcodes (011, 100, 101) with ld=0 are detected at acceptance:
  - illegal pulses in the EXEC cycle.
  - err_count increments, saturating at all-ones.
  - The FSM goes EXEC→IDLE, skipping WB. No writeback, no wb_valid.
- Load immediate never flags illegal, whatever instr_op holds.
- Arithmetic is performed by the ALU: 8-bit modulo results; SLT is unsigned, producing 0 or 1.
- alu_control, alu_a and alu_b hold the operand-register values outside EXEC; they are not gated.
- Back-to-back dependency (instruction N+1 reads N's rd) is safe without forwarding, because the next acceptance occurs only after the WB write.
- dbg_data reflects the register write from the cycle after WB.

## Timing
- Acceptance at edge T (instr_valid && instr_ready high before edge T):
  - EXEC during cycle T..T+1.
  - wb_valid high during cycle T+1..T+2.
  - instr_ready high again after edge T+2.
  - Throughput: one instruction per 3 cycles.
- Illegal op: illegal high for the EXEC cycle; instr_ready returns one cycle earlier (2-cycle occupancy).
- instr_valid may stay high across instructions; each IDLE cycle with valid high accepts exactly one instruction.
- Inputs are ignored when instr_ready is low.
- Reset (rst_n low at an edge):
  - state = IDLE, all registers = 0.
  - alu_control = 000, alu_a = alu_b = 0.
  - wb_valid = 0, wb_rd = 0, wb_data = 0, illegal = 0, err_count = 0.
  - instr_ready = 0 while rst_n is low.
- Reset mid-operation (in EXEC or WB) abandons the instruction: no writeback and the register file is cleared.

## Test plan
- Reset, then LD r1←200, LD r2←100, ADD r3=r1+r2 → wb_valid with wb_rd=3, wb_data=44; dbg_addr=3 reads 44; each instruction occupies 3 cycles.
- LD r1←5, LD r2←7, SUB r4=r1−r2 → wb_data=254. SLT r5=r2<r1 → 0. SLT r5=r1<r2 → 1.
- LD r1←0xF0, LD r2←0x3C: AND → 0x30, OR → 0xFC. Dependent chain ADD r1=r1+r1 issued twice back-to-back → 0xE0, then 0xC0.
- Opcode 011 with ld=0 → illegal pulse, no wb_valid, err_count=1, instr_ready back after 2 cycles. Drive 300 illegal ops → err_count saturates at 255.
- LD r0←0x55 with ZERO_REG=1 → wb_valid with wb_data=0x55, dbg read of r0 = 0. ADD r6=r0+r0 → 0.
- Drop rst_n during EXEC of ADD r3 → no wb_valid; after release all registers read 0, err_count=0, instr_ready=1 the first cycle after rst_n returns high.

Source files
------------

// File: rtl/alu_regfile_seq.sv
// rtl/alu_regfile_seq.sv - operand-issue and writeback sequencer for the 8-bit ALU
//
// Holds an 8 x 8-bit register file, accepts one instruction at a time
// (IDLE -> EXEC -> WB), drives the ALU from registered operands and writes
// the captured result back.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   instr_valid/instr_ready         instruction handshake
//   instr_ld/op/rd/ra/rb/imm        instruction fields
//   alu_control, alu_a, alu_b       registered ALU inputs
//   alu_result                      combinational ALU result
//   wb_valid, wb_rd, wb_data        one-cycle writeback strobe
//   illegal, err_count              illegal-op pulse and saturating count
//   dbg_addr, dbg_data              combinational register-file debug read
module alu_regfile_seq #(
    parameter bit ZERO_REG = 1'b1,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             instr_ld,
    input  logic [2:0]       instr_op,
    input  logic [2:0]       instr_rd,
    input  logic [2:0]       instr_ra,
    input  logic [2:0]       instr_rb,
    input  logic [7:0]       instr_imm,
    output logic [2:0]       alu_control,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [7:0]       alu_result,
    output logic             wb_valid,
    output logic [2:0]       wb_rd,
    output logic [7:0]       wb_data,
    output logic             illegal,
    output logic [ERR_W-1:0] err_count,
    input  logic [2:0]       dbg_addr,
    output logic [7:0]       dbg_data
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t     state;
    logic [7:0] regs [8];
    logic       ld_q;
    logic [2:0] op_q;
    logic [2:0] rd_q;
    logic [7:0] imm_q;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       bad_q;
    logic       bad_op;
    logic [7:0] rd_a;
    logic [7:0] rd_b;

    // r0 reads as zero when ZERO_REG is set, independent of array contents
    function automatic logic [7:0] rf_read(input logic [2:0] addr, input logic [7:0] value);
        return (ZERO_REG && (addr == 3'd0)) ? 8'd0 : value;
    endfunction

    assign rd_a     = rf_read(instr_ra, regs[instr_ra]);
    assign rd_b     = rf_read(instr_rb, regs[instr_rb]);
    assign dbg_data = rf_read(dbg_addr, regs[dbg_addr]);

    // Loads never flag illegal, whatever instr_op holds
    assign bad_op = !instr_ld &&
                    ((instr_op == 3'b011) || (instr_op == 3'b100) || (instr_op == 3'b101));

    assign instr_ready = (state == IDLE) && rst_n;

    // ALU inputs follow the operand registers at all times (not gated to EXEC)
    assign alu_control = op_q;
    assign alu_a       = opa;
    assign alu_b       = opb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 8'd0;
            end
            ld_q      <= 1'b0;
            op_q      <= 3'd0;
            rd_q      <= 3'd0;
            imm_q     <= 8'd0;
            opa       <= 8'd0;
            opb       <= 8'd0;
            bad_q     <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= 3'd0;
            wb_data   <= 8'd0;
            illegal   <= 1'b0;
            err_count <= '0;
        end else begin
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ld_q  <= instr_ld;
                        op_q  <= instr_op;
                        rd_q  <= instr_rd;
                        imm_q <= instr_imm;
                        opa   <= rd_a;
                        opb   <= rd_b;
                        bad_q <= bad_op;
                        if (bad_op) begin
                            // registered here so the pulse lands in the EXEC cycle
                            illegal <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                        end
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (bad_q) begin
                        state <= IDLE;
                    end else begin
                        // wb_data doubles as the result register
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= ld_q ? imm_q : alu_result;
                        state    <= WB;
                    end
                end
                WB: begin
                    if (!(ZERO_REG && (rd_q == 3'd0))) begin
                        regs[rd_q] <= wb_data;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_regfile_seq.sv
// tb/tb_alu_regfile_seq.sv - self-checking bench for alu_regfile_seq
module tb_alu_regfile_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic       instr_ld;
    logic [2:0] instr_op;
    logic [2:0] instr_rd;
    logic [2:0] instr_ra;
    logic [2:0] instr_rb;
    logic [7:0] instr_imm;
    logic [2:0] alu_control;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       illegal;
    logic [7:0] err_count;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int last_acc = 0;
    int prev_acc = 0;

    logic [7:0]  mregs [8];
    logic [7:0]  merr;
    logic [10:0] q [$];

    localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, AND_ = 3'b000, OR_ = 3'b001, SLT = 3'b111;

    alu_regfile_seq #(.ZERO_REG(1'b1), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_ld(instr_ld), .instr_op(instr_op), .instr_rd(instr_rd),
        .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_imm(instr_imm),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal(illegal), .err_count(err_count),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU
    always_comb begin
        alu_result = 8'd0;
        case (alu_control)
            3'b010: alu_result = alu_a + alu_b;
            3'b110: alu_result = alu_a - alu_b;
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b111: alu_result = {7'd0, (alu_a < alu_b)};
            default: alu_result = 8'd0;
        endcase
    end

    // Scoreboard consumer: every writeback must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            checks++;
            if (q.size() == 0) begin
                $display("FAIL wb_unexpected got rd=%0d data=%0d required=no writeback", wb_rd, wb_data);
            end else begin
                logic [10:0] e;
                e = q.pop_front();
                if ({wb_rd, wb_data} !== e)
                    $display("FAIL wb_data got rd=%0d data=%0d required rd=%0d data=%0d",
                             wb_rd, wb_data, e[10:8], e[7:0]);
                else
                    passes++;
            end
        end
    end

    task automatic issue(input logic ld, input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] ra, input logic [2:0] rb, input logic [7:0] imm);
        int n;
        logic [7:0] a, b, r;
        logic bad;
        @(negedge clk);
        instr_ld = ld; instr_op = op; instr_rd = rd;
        instr_ra = ra; instr_rb = rb; instr_imm = imm;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!instr_ready) begin
            $display("FAIL issue_timeout ready=%0b required=1", instr_ready);
            instr_valid = 1'b0;
            return;
        end
        passes++;
        prev_acc = last_acc;
        last_acc = cyc;
        a = (ra == 3'd0) ? 8'd0 : mregs[ra];
        b = (rb == 3'd0) ? 8'd0 : mregs[rb];
        bad = !ld && (op == 3'b011 || op == 3'b100 || op == 3'b101);
        case (op)
            3'b010:  r = a + b;
            3'b110:  r = a - b;
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b111:  r = (a < b) ? 8'd1 : 8'd0;
            default: r = 8'd0;
        endcase
        if (ld) r = imm;
        if (bad) begin
            if (merr != 8'hFF) merr = merr + 8'd1;
        end else begin
            q.push_back({rd, r});
            if (rd != 3'd0) mregs[rd] = r;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (q.size() != 0)
            $display("FAIL drain_timeout pending=%0d required=0", q.size());
        else
            passes++;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            checks++;
            if (dbg_data !== mregs[i])
                $display("FAIL %s_r%0d got=%0d required=%0d", tag, i, dbg_data, mregs[i]);
            else
                passes++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({instr_ready, wb_valid, wb_rd, wb_data, illegal, err_count, alu_control, alu_a, alu_b} !== '0)
            $display("FAIL reset_outputs got ready=%0b wbv=%0b rd=%0d data=%0d ill=%0b err=%0d ctl=%0d a=%0d b=%0d required=all zero",
                     instr_ready, wb_valid, wb_rd, wb_data, illegal, err_count, alu_control, alu_a, alu_b);
        else
            passes++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) mregs[i] = 8'd0;
        merr = 8'd0;
        check_regs("reset");
    endtask

    task automatic test_add();
        issue(1'b1, 3'b000, 3'd1, 3'd0, 3'd0, 8'd200);
        issue(1'b1, 3'b000, 3'd2, 3'd0, 3'd0, 8'd100);
        checks++;
        if (last_acc - prev_acc !== 3)
            $display("FAIL occupancy_ld got=%0d required=3", last_acc - prev_acc);
        else
            passes++;
        issue(1'b0, ADD, 3'd3, 3'd1, 3'd2, 8'd0);
        checks++;
        if (last_acc - prev_acc !== 3)
            $display("FAIL occupancy_add got=%0d required=3", last_acc - prev_acc);
        else
            passes++;
        drain();
        dbg_addr = 3'd3;
        #1;
        checks++;
        if (dbg_data !== 8'd44)
            $display("FAIL add_dbg got=%0d required=44", dbg_data);
        else
            passes++;
    endtask

    task automatic test_sub_slt();
        issue(1'b1, 3'b000, 3'd1, 3'd0, 3'd0, 8'd5);
        issue(1'b1, 3'b000, 3'd2, 3'd0, 3'd0, 8'd7);
        issue(1'b0, SUB, 3'd4, 3'd1, 3'd2, 8'd0);
        issue(1'b0, SLT, 3'd5, 3'd2, 3'd1, 8'd0);
        issue(1'b0, SLT, 3'd5, 3'd1, 3'd2, 8'd0);
        drain();
        dbg_addr = 3'd4;
        #1;
        checks++;
        if (dbg_data !== 8'd254)
            $display("FAIL sub_dbg got=%0d required=254", dbg_data);
        else
            passes++;
    endtask

    task automatic test_logic_chain();
        issue(1'b1, 3'b000, 3'd1, 3'd0, 3'd0, 8'hF0);
        issue(1'b1, 3'b000, 3'd2, 3'd0, 3'd0, 8'h3C);
        issue(1'b0, AND_, 3'd3, 3'd1, 3'd2, 8'd0);
        issue(1'b0, OR_, 3'd4, 3'd1, 3'd2, 8'd0);
        issue(1'b0, ADD, 3'd1, 3'd1, 3'd1, 8'd0);
        issue(1'b0, ADD, 3'd1, 3'd1, 3'd1, 8'd0);
        drain();
        dbg_addr = 3'd1;
        #1;
        checks++;
        if (dbg_data !== 8'hC0)
            $display("FAIL chain_dbg got=%0h required=c0", dbg_data);
        else
            passes++;
        check_regs("logic");
    endtask

    task automatic test_illegal();
        issue(1'b0, 3'b011, 3'd6, 3'd1, 3'd2, 8'd0);
        checks++;
        if (illegal !== 1'b1 || wb_valid !== 1'b0)
            $display("FAIL illegal_pulse got ill=%0b wbv=%0b required ill=1 wbv=0", illegal, wb_valid);
        else
            passes++;
        @(posedge clk);
        #1;
        checks++;
        if (illegal !== 1'b0 || instr_ready !== 1'b1 || err_count !== merr)
            $display("FAIL illegal_after got ill=%0b ready=%0b err=%0d required ill=0 ready=1 err=%0d",
                     illegal, instr_ready, err_count, merr);
        else
            passes++;
        issue(1'b1, 3'b101, 3'd6, 3'd0, 3'd0, 8'd9);
        checks++;
        if (illegal !== 1'b0)
            $display("FAIL ld_not_illegal got=%0b required=0", illegal);
        else
            passes++;
        issue(1'b0, 3'b100, 3'd6, 3'd0, 3'd0, 8'd0);
        issue(1'b0, 3'b101, 3'd6, 3'd0, 3'd0, 8'd0);
        checks++;
        if (last_acc - prev_acc !== 2)
            $display("FAIL occupancy_illegal got=%0d required=2", last_acc - prev_acc);
        else
            passes++;
        for (int i = 0; i < 300; i++)
            issue(1'b0, 3'(3 + (i % 3)), 3'(i), 3'd1, 3'd2, 8'd0);
        drain();
        checks++;
        if (err_count !== merr || merr !== 8'd255)
            $display("FAIL err_saturate got=%0d required=%0d", err_count, merr);
        else
            passes++;
        check_regs("illegal");
    endtask

    task automatic test_zero_reg();
        issue(1'b1, 3'b000, 3'd0, 3'd0, 3'd0, 8'h55);
        issue(1'b0, ADD, 3'd6, 3'd0, 3'd0, 8'd0);
        drain();
        dbg_addr = 3'd0;
        #1;
        checks++;
        if (dbg_data !== 8'd0)
            $display("FAIL r0_dbg got=%0d required=0", dbg_data);
        else
            passes++;
        check_regs("zero");
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        instr_ld = 1'b0; instr_op = ADD; instr_rd = 3'd3;
        instr_ra = 3'd1; instr_rb = 3'd2; instr_imm = 8'd0;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b0)
            $display("FAIL ready_in_reset got=%0b required=0", instr_ready);
        else
            passes++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) mregs[i] = 8'd0;
        merr = 8'd0;
        #1;
        checks++;
        if (instr_ready !== 1'b1 || err_count !== 8'd0)
            $display("FAIL after_reset got ready=%0b err=%0d required ready=1 err=0", instr_ready, err_count);
        else
            passes++;
        check_regs("midreset");
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0; instr_ld = 1'b0; instr_op = 3'd0; instr_rd = 3'd0;
        instr_ra = 3'd0; instr_rb = 3'd0; instr_imm = 8'd0; dbg_addr = 3'd0;
        merr = 8'd0;
        for (int i = 0; i < 8; i++) mregs[i] = 8'd0;
        test_reset();
        test_add();
        test_sub_slt();
        test_logic_chain();
        test_illegal();
        test_zero_reg();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
